// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Buffers bytes offered on data_in_i in a small FIFO and sends them on a
//   single 8N1 serial line (start bit, 8 data bits LSB first, stop bit).
//   The core side has no backpressure, so a byte offered while the FIFO is
//   full is dropped and a sticky overflow flag is raised.
//
// Ports
//   clock_i           system clock, rising edge
//   reset_i           synchronous active-high reset
//   data_in_i[8]      valid strobe; data_in_i[7:0] = byte
//   overflow_clear_i  clears the sticky overflow flag
//   tx_o              serial line, idles high, registered
//   busy_o            high while a frame is on the line
//   fifo_count_o      bytes queued, excluding the byte being shifted out
//   full_o            fifo_count_o == FIFO_DEPTH
//   overflow_o        sticky, set when an offered byte is dropped
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high); pops the next byte directly into START if queued
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned DEPTH_LOG2   = 3
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [8:0]            data_in_i,
  input  logic                  overflow_clear_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic [DEPTH_LOG2:0]   fifo_count_o,
  output logic                  full_o,
  output logic                  overflow_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]    BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;

  logic [7:0]            mem_q [FIFO_DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic                  pop;
  logic                  push_ok;
  logic                  drop;
  logic                  bit_last;
  logic                  fifo_empty;

  assign bit_last   = (bit_cnt_q == BIT_LAST);
  assign fifo_empty = (count_q == '0);

  // A full FIFO still accepts a byte when the head is popped at the same edge.
  assign push_ok = data_in_i[8] && ((count_q != COUNT_FULL) || pop);
  assign drop    = data_in_i[8] && !push_ok;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          idx_d     = '0;
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is decided from the next state so tx_o comes straight
    // from a flop and changes on the same edge as the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A drop at the same edge as a clear leaves the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clear_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clock_i) begin
    if (!reset_i && push_ok) begin
      mem_q[wr_ptr_q] <= data_in_i[7:0];
    end
  end

  assign tx_o         = tx_q;
  assign busy_o       = (state_q != IDLE);
  assign fifo_count_o = count_q;
  assign full_o       = (count_q == COUNT_FULL);
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int DLOG2 = 3;

  logic       clock_i;
  logic       reset_i;
  logic [8:0] data_in_i;
  logic       overflow_clear_i;
  logic       tx_o;
  logic       busy_o;
  logic [3:0] fifo_count_o;
  logic       full_o;
  logic       overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q [$];
  logic       mon_abort;

  uart_tx_serializer #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .DEPTH_LOG2   (DLOG2)
  ) dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .data_in_i        (data_in_i),
    .overflow_clear_i (overflow_clear_i),
    .tx_o             (tx_o),
    .busy_o           (busy_o),
    .fifo_count_o     (fifo_count_o),
    .full_o           (full_o),
    .overflow_o       (overflow_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish before 300000 ns");
    $fatal(1, "watchdog expired");
  end

  // Serial receiver: samples mid-bit, compares each frame with the scoreboard.
  task automatic mon_wait(input int n);
    repeat (n) begin
      @(negedge clock_i);
      if (reset_i) mon_abort = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] rx;
    logic       stop_bit;
    logic [7:0] exp_b;
    forever begin
      @(negedge clock_i);
      if (!reset_i && tx_o === 1'b0) begin
        mon_abort = 1'b0;
        for (int k = 0; k < 8; k++) begin
          mon_wait((k == 0) ? (CPB + CPB / 2) : CPB);
          rx[k] = tx_o;
        end
        mon_wait(CPB);
        stop_bit = tx_o;
        if (!mon_abort) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rx_unexpected: got frame %02h, required no frame", rx);
          end else begin
            exp_b = exp_q.pop_front();
            if (rx !== exp_b) begin
              n_fail++;
              $display("FAIL rx_byte: got %02h, required %02h", rx, exp_b);
            end
          end
          n_checks++;
          if (stop_bit !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_stop: got %b, required 1", stop_bit);
          end
        end
      end
    end
  end

  task automatic wait_drain(input int bound, input string name);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || busy_o !== 1'b0) && i < bound) begin
      @(negedge clock_i);
      i++;
    end
    n_checks++;
    if (exp_q.size() != 0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d bytes pending busy=%b after %0d cycles, required 0 pending busy=0",
               name, exp_q.size(), busy_o, bound);
    end
  endtask

  task automatic test_reset();
    reset_i          = 1'b1;
    data_in_i        = '0;
    overflow_clear_i = 1'b0;
    repeat (3) @(negedge clock_i);
    reset_i = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock_i);
      n_checks++;
      if ({tx_o, busy_o, fifo_count_o, full_o, overflow_o} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_idle c%0d: tx=%b busy=%b count=%0d full=%b ovf=%b, required 1 0 0 0 0",
                 c, tx_o, busy_o, fifo_count_o, full_o, overflow_o);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic       exp_tx;
    int         slot;
    b = 8'h55;
    data_in_i = {1'b1, b};
    exp_q.push_back(b);
    @(negedge clock_i);
    data_in_i = '0;
    n_checks++;
    if (fifo_count_o !== 4'd1 || tx_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_queued: count=%0d tx=%b busy=%b, required 1 1 0", fifo_count_o, tx_o, busy_o);
    end
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clock_i);
      slot = c / CPB;
      if (slot == 0)      exp_tx = 1'b0;
      else if (slot == 9) exp_tx = 1'b1;
      else                exp_tx = b[slot-1];
      n_checks++;
      if (tx_o !== exp_tx || busy_o !== 1'b1) begin
        n_fail++;
        $display("FAIL single_wave c%0d: tx=%b busy=%b, required tx=%b busy=1", c, tx_o, busy_o, exp_tx);
      end
    end
    @(negedge clock_i);
    n_checks++;
    if (busy_o !== 1'b0 || tx_o !== 1'b1 || fifo_count_o !== 4'd0) begin
      n_fail++;
      $display("FAIL single_done: busy=%b tx=%b count=%0d, required 0 1 0", busy_o, tx_o, fifo_count_o);
    end
    wait_drain(100, "single");
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    int peak, busy_cyc;
    peak = 0;
    busy_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      b = 8'h41 + 8'(i);
      data_in_i = {1'b1, b};
      exp_q.push_back(b);
      @(negedge clock_i);
      if (int'(fifo_count_o) > peak) peak = int'(fifo_count_o);
      if (busy_o === 1'b1) busy_cyc++;
    end
    data_in_i = '0;
    repeat (118) begin
      @(negedge clock_i);
      if (int'(fifo_count_o) > peak) peak = int'(fifo_count_o);
      if (busy_o === 1'b1) busy_cyc++;
    end
    @(negedge clock_i);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: busy=%b, required 0", busy_o);
    end
    n_checks++;
    if (busy_cyc != 120) begin
      n_fail++;
      $display("FAIL b2b_busy_cycles: got %0d, required 120", busy_cyc);
    end
    n_checks++;
    if (peak != 2) begin
      n_fail++;
      $display("FAIL b2b_peak_count: got %0d, required 2", peak);
    end
    wait_drain(100, "b2b");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) begin
      data_in_i = {1'b1, 8'(i)};
      if (i < 9) exp_q.push_back(8'(i));
      @(negedge clock_i);
      if (i == 7) begin
        n_checks++;
        if (fifo_count_o !== 4'd7 || full_o !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_seven: count=%0d full=%b, required 7 0", fifo_count_o, full_o);
        end
      end
      if (i == 8) begin
        n_checks++;
        if (fifo_count_o !== 4'd8 || full_o !== 1'b1 || overflow_o !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_full: count=%0d full=%b ovf=%b, required 8 1 0", fifo_count_o, full_o, overflow_o);
        end
      end
      if (i == 9) begin
        n_checks++;
        if (fifo_count_o !== 4'd8 || full_o !== 1'b1 || overflow_o !== 1'b1) begin
          n_fail++;
          $display("FAIL ovf_drop: count=%0d full=%b ovf=%b, required 8 1 1", fifo_count_o, full_o, overflow_o);
        end
      end
    end
    data_in_i = '0;
    overflow_clear_i = 1'b1;
    @(negedge clock_i);
    overflow_clear_i = 1'b0;
    n_checks++;
    if (overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%b, required 0", overflow_o);
    end
    wait_drain(600, "ovf");
    n_checks++;
    if (overflow_o !== 1'b0 || fifo_count_o !== 4'd0 || full_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_after: ovf=%b count=%0d full=%b, required 0 0 0", overflow_o, fifo_count_o, full_o);
    end
  endtask

  task automatic test_push_at_pop();
    for (int i = 0; i < 9; i++) begin
      data_in_i = {1'b1, 8'hB0 + 8'(i)};
      exp_q.push_back(8'hB0 + 8'(i));
      @(negedge clock_i);
    end
    data_in_i = '0;
    n_checks++;
    if (fifo_count_o !== 4'd8 || full_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pap_filled: count=%0d full=%b, required 8 1", fifo_count_o, full_o);
    end
    repeat (32) @(negedge clock_i);
    n_checks++;
    if (busy_o !== 1'b1 || tx_o !== 1'b1 || fifo_count_o !== 4'd8) begin
      n_fail++;
      $display("FAIL pap_stop: busy=%b tx=%b count=%0d, required 1 1 8", busy_o, tx_o, fifo_count_o);
    end
    data_in_i = {1'b1, 8'hB9};
    exp_q.push_back(8'hB9);
    @(negedge clock_i);
    data_in_i = '0;
    n_checks++;
    if (fifo_count_o !== 4'd8 || full_o !== 1'b1 || overflow_o !== 1'b0 || tx_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pap_accept: count=%0d full=%b ovf=%b tx=%b, required 8 1 0 0",
               fifo_count_o, full_o, overflow_o, tx_o);
    end
    wait_drain(600, "pap");
  endtask

  task automatic test_reset_mid();
    logic [7:0] bytes [4];
    bytes[0] = 8'hA5;
    bytes[1] = 8'h01;
    bytes[2] = 8'h02;
    bytes[3] = 8'h03;
    for (int i = 0; i < 4; i++) begin
      data_in_i = {1'b1, bytes[i]};
      exp_q.push_back(bytes[i]);
      @(negedge clock_i);
    end
    data_in_i = '0;
    n_checks++;
    if (fifo_count_o !== 4'd3 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_queued: count=%0d busy=%b, required 3 1", fifo_count_o, busy_o);
    end
    repeat (7) @(negedge clock_i);
    reset_i = 1'b1;
    @(negedge clock_i);
    n_checks++;
    if ({tx_o, busy_o, fifo_count_o, full_o, overflow_o} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rmid_reset: tx=%b busy=%b count=%0d full=%b ovf=%b, required 1 0 0 0 0",
               tx_o, busy_o, fifo_count_o, full_o, overflow_o);
    end
    @(negedge clock_i);
    reset_i = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 100; c++) begin
      @(negedge clock_i);
      n_checks++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_count_o !== 4'd0) begin
        n_fail++;
        $display("FAIL rmid_quiet c%0d: tx=%b busy=%b count=%0d, required 1 0 0", c, tx_o, busy_o, fifo_count_o);
      end
    end
  endtask

  initial begin
    mon_abort        = 1'b0;
    reset_i          = 1'b1;
    data_in_i        = '0;
    overflow_clear_i = 1'b0;
    test_reset();
    repeat (5) @(negedge clock_i);
    test_single();
    test_back_to_back();
    test_overflow();
    test_push_at_pop();
    test_reset_mid();
    repeat (5) @(negedge clock_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Sits directly downstream of `top`'s `uart_data_out` port (bit 8 = valid strobe, bits 7:0 = byte).
- Buffers bytes the CPU emits in a small FIFO and serializes them onto a single 8N1 transmit line at a programmable bit period.
- Replaces the simulation-only character dump with synthesizable hardware.
- Reports buffer occupancy and a sticky overflow flag, because the core-side interface has no backpressure.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 8, number of byte entries; must be a power of two, at least 2.
- DEPTH_LOG2, 3, log2(FIFO_DEPTH).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  9  bit 8 = valid strobe, bits 7:0 = byte; one byte is offered per cycle in which bit 8 is high.
- overflow_clear  input  1  clears the sticky overflow flag.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line (START, DATA or STOP state).
- fifo_count  output  DEPTH_LOG2+1  number of queued bytes, not counting the byte being shifted out.
- full  output  1  high when fifo_count == FIFO_DEPTH.
- overflow  output  1  sticky; set when an offered byte is dropped.

Behaviour:
- Reset: sampled at the rising clock edge and takes priority over all other activity, including a frame in progress.
  - Values after reset: tx=1, busy=0, fifo_count=0, full=0, overflow=0, FSM=IDLE.
  - A frame interrupted by reset is abandoned; tx returns to 1 on the next edge.
- Push: at an edge where data_in[8]=1, the byte is written at the write pointer if either:
  - fifo_count < FIFO_DEPTH, or
  - a pop occurs at the same edge.
- Drop: otherwise the byte is discarded and overflow is set to 1.
- Overflow clear:
  - overflow_clear=1 clears overflow at that edge.
  - If a drop happens at the same edge, set wins.
- Pointers: write and read pointers are DEPTH_LOG2 bits wide and wrap modulo FIFO_DEPTH.
- fifo_count:
  - +1 on push only; -1 on pop only; unchanged on simultaneous push and pop.
  - full is derived from fifo_count.
- FSM states: IDLE, START, DATA, STOP. A bit counter counts 0..CLKS_PER_BIT-1; an index counter counts 0..7.
- IDLE:
  - tx=1.
  - If fifo_count>0 at an edge: pop the head byte into the shift register, clear the bit counter, go to START.
  - A byte pushed at edge N is therefore popped at edge N+1, and tx falls at edge N+1.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with index=0.
- DATA:
  - tx = shift[0], LSB first, each bit held CLKS_PER_BIT cycles.
  - Shift right after each bit; after bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the final cycle's edge:
  - if fifo_count>0, pop and go directly to START (no idle gap);
  - else go to IDLE.
- Frame timing:
  - Exactly 10*CLKS_PER_BIT cycles per frame.
  - Back-to-back frames are contiguous.
- busy: 1 in START, DATA and STOP; 0 in IDLE.
- tx is driven from a register (no combinational path from data_in).
- Pushes during an active frame never disturb the shift register.

Test Plan:
- Reset, no input, 50 cycles -> tx=1, busy=0, fifo_count=0, full=0, overflow=0 throughout.
- CLKS_PER_BIT=4: push 0x55 at edge 10 -> tx falls at edge 11, then:
  - bits 1,0,1,0,1,0,1,0 each held 4 cycles;
  - stop bit high from edge 47 to 51;
  - busy=0 from edge 51.
- Push 0x41, 0x42, 0x43 on three consecutive cycles -> three contiguous 40-cycle frames with no idle gap; fifo_count peaks at 2; busy stays high for 120 cycles.
- Push 10 bytes 0x00..0x09 on consecutive cycles (FIFO_DEPTH=8) -> 0x00 is popped into the shifter and 0x01..0x08 are queued; 0x09 arrives with full=1 and no pop, so it is dropped.
  - full=1 and overflow=1 result.
  - The line carries exactly 0x00..0x08 in order.
  - Pulse overflow_clear -> overflow returns to 0.
- Fill the FIFO, then push again at the edge a STOP-to-START pop occurs -> byte accepted, fifo_count unchanged at 8, overflow stays 0.
- Assert reset mid-DATA of 0xA5 with 3 bytes queued -> next edge: tx=1, busy=0, fifo_count=0, overflow=0; no further frames.
